seg7_scan_driver: RTL and testbench



---
 rtl/seg7_pkg.sv | 20 ++
 rtl/seg7_decode.sv | 26 ++
 rtl/seg7_scan_driver.sv | 152 +++++++++++++++
 tb/tb_seg7_scan_driver.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared segment encodings for the seven-segment scan driver.
// Patterns are active-low, ordered {g,f,e,d,c,b,a}.
package seg7_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_0    = 7'b100_0000;
  localparam seg_t SEG_1    = 7'b111_1001;
  localparam seg_t SEG_2    = 7'b010_0100;
  localparam seg_t SEG_3    = 7'b011_0000;
  localparam seg_t SEG_4    = 7'b001_1001;
  localparam seg_t SEG_5    = 7'b001_0010;
  localparam seg_t SEG_6    = 7'b000_0010;
  localparam seg_t SEG_7    = 7'b111_1000;
  localparam seg_t SEG_8    = 7'b000_0000;
  localparam seg_t SEG_9    = 7'b001_0000;
  localparam seg_t SEG_DASH = 7'b011_1111;
  localparam seg_t SEG_OFF  = 7'b111_1111;

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD-to-segment decoder; non-decimal codes render as a dash.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] code_i,
  output seg_t       seg_o
);

  always_comb begin
    seg_o = SEG_DASH;
    case (code_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed seven-segment driver with double-buffered BCD load and blink.
// Define SEG7_LZ_BLANK_EN to blank leading zeros (digit 0 is never blanked).
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 3,
  parameter int unsigned SCAN_DIV     = 50000,
  parameter int unsigned BLINK_FRAMES = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  input  logic                    load,
  input  logic                    blink_en,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_start
);

  localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned PW = $clog2(SCAN_DIV);
  localparam int unsigned BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [PW-1:0]           presc_q, presc_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
  logic [4*NUM_DIGITS-1:0] active_q, active_d;
  logic                    pending_q, pending_d;
  logic [BW-1:0]           bcnt_q, bcnt_d;
  logic                    phase_on_q, phase_on_d;

  seg_t                    seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic                    fs_q, fs_d;

  logic                    presc_last, idx_last, frame_wrap;
  logic [3:0]              cur_code;
  logic                    cur_dp, cur_blank, show;
  logic [NUM_DIGITS-1:0]   lz_blank;
  seg_t                    dec_seg;

  // Scan timing and frame-boundary buffer/blink bookkeeping.
  always_comb begin
    presc_last = (presc_q == PW'(SCAN_DIV - 1));
    idx_last   = (idx_q == IW'(NUM_DIGITS - 1));
    frame_wrap = presc_last && idx_last;

    presc_d = presc_last ? '0 : presc_q + 1'b1;
    idx_d   = idx_q;
    if (presc_last) begin
      idx_d = idx_last ? '0 : idx_q + 1'b1;
    end

    shadow_d  = load ? bcd_in : shadow_q;
    active_d  = active_q;
    pending_d = pending_q | load;
    // A load coinciding with the copy stays pending for the following frame.
    if (frame_wrap && pending_q) begin
      active_d  = shadow_q;
      pending_d = load;
    end

    bcnt_d     = bcnt_q;
    phase_on_d = phase_on_q;
    if (frame_wrap) begin
      if (bcnt_q == BW'(BLINK_FRAMES - 1)) begin
        bcnt_d     = '0;
        phase_on_d = ~phase_on_q;
      end else begin
        bcnt_d = bcnt_q + 1'b1;
      end
    end
  end

`ifdef SEG7_LZ_BLANK_EN
  logic zero_run;

  always_comb begin
    lz_blank = '0;
    zero_run = 1'b1;
    for (int k = int'(NUM_DIGITS) - 1; k >= 1; k--) begin
      zero_run    = zero_run && (active_q[4*k +: 4] == 4'd0);
      lz_blank[k] = zero_run;
    end
  end
`else
  assign lz_blank = '0;
`endif

  always_comb begin
    cur_code  = '0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    for (int k = 0; k < int'(NUM_DIGITS); k++) begin
      if (idx_q == IW'(k)) begin
        cur_code  = active_q[4*k +: 4];
        cur_dp    = dp_mask[k];
        cur_blank = lz_blank[k];
      end
    end
  end

  seg7_decode u_decode (
    .code_i (cur_code),
    .seg_o  (dec_seg)
  );

  always_comb begin
    show  = !(blink_en && !phase_on_q);
    seg_d = (show && !cur_blank) ? dec_seg : SEG_OFF;
    dp_d  = show ? ~cur_dp : 1'b1;
    an_d  = ~(NUM_DIGITS'(1) << idx_q);
    fs_d  = (idx_q == '0) && (presc_q == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q    <= '0;
      idx_q      <= '0;
      shadow_q   <= '0;
      active_q   <= '0;
      pending_q  <= 1'b0;
      bcnt_q     <= '0;
      phase_on_q <= 1'b1;
      seg_q      <= SEG_OFF;
      dp_q       <= 1'b1;
      an_q       <= '1;
      fs_q       <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      idx_q      <= idx_d;
      shadow_q   <= shadow_d;
      active_q   <= active_d;
      pending_q  <= pending_d;
      bcnt_q     <= bcnt_d;
      phase_on_q <= phase_on_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
      an_q       <= an_d;
      fs_q       <= fs_d;
    end
  end

  assign seg         = seg_q;
  assign dp          = dp_q;
  assign an          = an_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver: a frame-level model predicts every output cycle.
module tb_seg7_scan_driver;

  localparam int unsigned ND    = 3;
  localparam int unsigned SD    = 4;
  localparam int unsigned BF    = 1;
  localparam int unsigned FRAME = ND * SD;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [11:0] bcd_in = '0;
  logic        load = 1'b0;
  logic        blink_en = 1'b0;
  logic [2:0]  dp_mask = '0;
  logic [6:0]  seg;
  logic        dp;
  logic [2:0]  an;
  logic        frame_start;

  seg7_scan_driver #(
    .NUM_DIGITS   (ND),
    .SCAN_DIV     (SD),
    .BLINK_FRAMES (BF)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .bcd_in      (bcd_in),
    .load        (load),
    .blink_en    (blink_en),
    .dp_mask     (dp_mask),
    .seg         (seg),
    .dp          (dp),
    .an          (an),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [6:0] seg;
    logic       dp;
    logic [2:0] an;
    logic       fs;
  } obs_t;

  obs_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [6:0] seg_of(input logic [3:0] v);
    case (v)
      4'd0: return 7'b100_0000;
      4'd1: return 7'b111_1001;
      4'd2: return 7'b010_0100;
      4'd3: return 7'b011_0000;
      4'd4: return 7'b001_1001;
      4'd5: return 7'b001_0010;
      4'd6: return 7'b000_0010;
      4'd7: return 7'b111_1000;
      4'd8: return 7'b000_0000;
      4'd9: return 7'b001_0000;
      default: return 7'b011_1111;
    endcase
  endfunction

  // Reference model: the cycle count since reset release fixes digit, frame and blink phase;
  // each frame shows the last value loaded before that frame's boundary edge.
  initial begin : model
    int unsigned n;
    int unsigned f;
    int unsigned d;
    logic [11:0] last_ld;
    logic [11:0] next_val;
    logic [11:0] frame_val;
    bit          on;
    bit          blank;
    obs_t        e;
    n = 0;
    last_ld = '0;
    next_val = '0;
    frame_val = '0;
    forever begin
      @(posedge clk);
      if (reset) begin
        n = 0;
        last_ld = '0;
        next_val = '0;
        frame_val = '0;
        e = {7'b111_1111, 1'b1, 3'b111, 1'b0};
      end else begin
        if (n % FRAME == 0) frame_val = next_val;
        if ((n + 1) % FRAME == 0) next_val = last_ld;
        f = n / FRAME;
        d = (n % FRAME) / SD;
        on = !blink_en || ((f / BF) % 2 == 0);
        blank = 1'b0;
`ifdef SEG7_LZ_BLANK_EN
        if (d != 0 && (frame_val >> (4 * d)) == 0) blank = 1'b1;
`endif
        e.seg = (!on || blank) ? 7'b111_1111 : seg_of(frame_val[4*d +: 4]);
        e.dp  = on ? !dp_mask[d] : 1'b1;
        e.an  = ~(3'b001 << d);
        e.fs  = (n % FRAME == 0);
        if (load) last_ld = bcd_in;
        n++;
      end
      exp_q.push_back(e);
    end
  end

  initial begin : monitor
    obs_t e;
    obs_t a;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {seg, dp, an, frame_start};
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL outputs t=%0t got seg=%b dp=%b an=%b fs=%b required seg=%b dp=%b an=%b fs=%b",
                   $time, a.seg, a.dp, a.an, a.fs, e.seg, e.dp, e.an, e.fs);
        end
      end
    end
  end

  task automatic do_load(input logic [11:0] v);
    bcd_in = v;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  initial begin : stim
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (2 * FRAME + 5) @(negedge clk);
    do_load(12'h259);
    repeat (2 * FRAME + 3) @(negedge clk);
    dp_mask = 3'b010;
    do_load(12'h1A3);
    repeat (2 * FRAME) @(negedge clk);
    blink_en = 1'b1;
    repeat (4 * FRAME) @(negedge clk);
    blink_en = 1'b0;
    dp_mask = 3'b000;
    do_load(12'h005);
    repeat (2 * FRAME) @(negedge clk);
    do_load(12'h000);
    repeat (2 * FRAME) @(negedge clk);
    // Pending load must be discarded by reset.
    repeat (5) @(negedge clk);
    do_load(12'h777);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (2 * FRAME + 2) @(negedge clk);
    for (int i = 0; i < 1500; i++) begin
      load = ($urandom_range(7) == 0);
      bcd_in = 12'($urandom);
      dp_mask = 3'($urandom);
      if ($urandom_range(99) == 0) blink_en = ~blink_en;
      reset = ($urandom_range(299) == 0);
      @(negedge clk);
    end
    load = 1'b0;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    if (checks < 12) begin
      errors++;
      $display("FAIL check_count got %0d required at least 12", checks);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
